// File: rtl/history_query_arbiter_pkg.sv
// Shared types and constants for the history query arbiter.
// The WAIT-state timeout is compiled in only when QUERY_TIMEOUT_EN is defined.
package gouram_query_pkg;

  localparam int TIME_W = 32;
  localparam int NO_HIT = -1;

  typedef struct packed {
    logic signed [TIME_W-1:0] start_time;
    logic signed [TIME_W-1:0] end_time;
  } time_range_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } query_state_e;

endpackage

// File: rtl/history_query_arbiter_rr.sv
// Combinational round-robin picker.
// Returns the first requester at or after the pointer, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j;
    logic [IDX_W-1:0] j_idx;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      j_idx = IDX_W'(j);
      if (!any && req[j_idx]) begin
        any          = 1'b1;
        grant[j_idx] = 1'b1;
        idx          = j_idx;
      end
    end
  end

endmodule

// File: rtl/history_query_arbiter.sv
// Shares one signal-history range-query engine between NUM_REQ trackers, round-robin.
// Define QUERY_TIMEOUT_EN to abandon queries the engine never answers within TIMEOUT_CYCLES.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no query in flight; arbitrate pending requests
// S_ISSUE | range captured; short-circuit empty windows or pulse recalc
// S_WAIT  | engine evaluating; first cycle ignores eng_done_i (stale)
module history_query_arbiter
  import gouram_query_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIME_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ-1:0][2*TIME_W-1:0]  req_range_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [TIME_W-1:0]                 rsp_time_o,
  output logic                              eng_recalc_o,
  output logic [2*TIME_W-1:0]               eng_range_o,
  input  logic                              eng_done_i,
  input  logic [TIME_W-1:0]                 eng_result_i,
  output logic                              busy_o,
  output logic                              timeout_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("history_query_arbiter: unsupported parameter values");
  end

  query_state_e             state;
  logic [IDX_W-1:0]         rr_ptr;
  logic [IDX_W-1:0]         gnt_idx;
  logic signed [TIME_W-1:0] cap_start;
  logic signed [TIME_W-1:0] cap_end;
  logic                     wait_first;

  logic [NUM_REQ-1:0]       arb_grant;
  logic [IDX_W-1:0]         arb_idx;
  logic                     arb_any;

`ifdef QUERY_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid_i),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      gnt_idx      <= '0;
      cap_start    <= '0;
      cap_end      <= '0;
      wait_first   <= 1'b0;
      req_ready_o  <= '0;
      rsp_valid_o  <= '0;
      rsp_time_o   <= '0;
      eng_recalc_o <= 1'b0;
      eng_range_o  <= '0;
      busy_o       <= 1'b0;
      timeout_o    <= 1'b0;
`ifdef QUERY_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          rsp_valid_o <= '0;
          timeout_o   <= 1'b0;
          if (arb_any) begin
            req_ready_o            <= arb_grant;
            gnt_idx                <= arb_idx;
            {cap_start, cap_end}   <= req_range_i[arb_idx];
            rr_ptr                 <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
            busy_o                 <= 1'b1;
            state                  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          req_ready_o <= '0;
          // An inverted window can never hit, so answer without touching the engine.
          if (cap_start > cap_end) begin
            rsp_time_o  <= TIME_W'(NO_HIT);
            rsp_valid_o <= NUM_REQ'(1) << gnt_idx;
            busy_o      <= 1'b0;
            state       <= S_IDLE;
          end else begin
            eng_range_o  <= {cap_start, cap_end};
            eng_recalc_o <= 1'b1;
            wait_first   <= 1'b1;
`ifdef QUERY_TIMEOUT_EN
            to_cnt       <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          eng_recalc_o <= 1'b0;
          wait_first   <= 1'b0;
          if (!wait_first && eng_done_i) begin
            rsp_time_o  <= eng_result_i;
            rsp_valid_o <= NUM_REQ'(1) << gnt_idx;
            busy_o      <= 1'b0;
            state       <= S_IDLE;
          end
`ifdef QUERY_TIMEOUT_EN
          else if (to_cnt == '0) begin
            rsp_time_o  <= TIME_W'(NO_HIT);
            rsp_valid_o <= NUM_REQ'(1) << gnt_idx;
            timeout_o   <= 1'b1;
            busy_o      <= 1'b0;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt - CNT_W'(1);
          end
`endif
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_history_query_arbiter.sv
// Self-checking bench for history_query_arbiter: directed scenarios plus a randomized phase,
// all checked every cycle against a query-timeline model (QUERY_TIMEOUT_EN selects timeout behaviour).
module tb_history_query_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 8;

  localparam int E_RANDOM = 0;
  localparam int E_DIRECT = 1;
  localparam int E_SILENT = 2;
  localparam int E_MANUAL = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req_valid;
  logic [N-1:0][2*W-1:0] req_range;
  logic [N-1:0]          req_ready;
  logic [N-1:0]          rsp_valid;
  logic [W-1:0]          rsp_time;
  logic                  eng_recalc;
  logic [2*W-1:0]        eng_range;
  logic                  eng_done;
  logic [W-1:0]          eng_result;
  logic                  busy;
  logic                  timeout;

  always #5 clk = ~clk;

  history_query_arbiter #(.NUM_REQ(N), .TIME_W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_range_i  (req_range),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_time_o   (rsp_time),
    .eng_recalc_o (eng_recalc),
    .eng_range_o  (eng_range),
    .eng_done_i   (eng_done),
    .eng_result_i (eng_result),
    .busy_o       (busy),
    .timeout_o    (timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] mk_range(input int s, input int e);
    return {W'(s), W'(e)};
  endfunction

  // Reference model: a query is a timeline measured from its grant edge.
  // age 1: empty window answered, else engine kicked; age>=3: engine answer accepted.
  int             m_cur;
  int             m_ptr;
  longint         cyc;
  longint         m_t;
  logic signed [W-1:0] m_s, m_e;
  logic [N-1:0]   x_ready, x_rsp_valid;
  logic [W-1:0]   x_rsp_time;
  logic           x_recalc, x_busy, x_timeout;
  logic [2*W-1:0] x_range;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur = -1; m_ptr = 0; cyc = 0; m_t = 0;
      x_ready = '0; x_rsp_valid = '0; x_rsp_time = '0; x_recalc = 1'b0;
      x_busy = 1'b0; x_timeout = 1'b0; x_range = '0;
    end else begin : model_step
      int age;
      cyc++;
      x_ready = '0; x_rsp_valid = '0; x_recalc = 1'b0; x_timeout = 1'b0;
      if (m_cur < 0) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (req_valid[j]) begin
            m_cur = j; m_t = cyc; m_ptr = (j + 1) % N;
            {m_s, m_e} = req_range[j];
            x_ready[j] = 1'b1;
            break;
          end
        end
      end else begin
        age = int'(cyc - m_t);
        if (age == 1) begin
          if (m_s > m_e) begin
            x_rsp_time = '1; x_rsp_valid[m_cur] = 1'b1; m_cur = -1;
          end else begin
            x_recalc = 1'b1; x_range = {m_s, m_e};
          end
        end else if (age >= 3 && eng_done) begin
          x_rsp_time = eng_result; x_rsp_valid[m_cur] = 1'b1; m_cur = -1;
        end
`ifdef QUERY_TIMEOUT_EN
        else if (age == TO + 1) begin
          x_rsp_time = '1; x_rsp_valid[m_cur] = 1'b1; x_timeout = 1'b1; m_cur = -1;
        end
`endif
      end
      x_busy = (m_cur >= 0);
    end
  end

  int outstanding = 0;
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0;
    end else begin
      check("req_ready", req_ready, x_ready);
      check("rsp_valid", rsp_valid, x_rsp_valid);
      check("rsp_time", rsp_time, x_rsp_time);
      check("eng_recalc", eng_recalc, x_recalc);
      check("eng_range", eng_range, x_range);
      check("busy", busy, x_busy);
      check("timeout", timeout, x_timeout);
      outstanding = outstanding + $countones(req_ready) - $countones(rsp_valid);
      check("one_in_flight", (outstanding >= 0 && outstanding <= 1), 1);
    end
  end

  // Engine stand-in
  int         eng_mode = E_SILENT;
  logic [W-1:0] dir_result = '0;
  int         dly = 0;
  always @(posedge clk) begin
    #1;
    case (eng_mode)
      E_RANDOM: begin
        eng_done   = ($urandom % 4 == 0);
        eng_result = ($urandom % 5 == 0) ? '1 : W'($urandom_range(0, 500));
        dly = 0;
      end
      E_DIRECT: begin
        if (dly != 0) begin eng_done = 1'b1; eng_result = dir_result; dly = 0; end
        else eng_done = 1'b0;
        if (eng_recalc) dly = 1;
      end
      E_SILENT: begin eng_done = 1'b0; dly = 0; end
      default: ;
    endcase
  end

  // Random requesters
  logic req_random = 1'b0;
  always @(posedge clk) begin
    #1;
    if (req_random) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          req_valid[i] = ($urandom % 4 == 0);
          req_range[i] = mk_range(int'($urandom_range(0, 60)) - 10, int'($urandom_range(0, 60)) - 10);
        end else if (!req_valid[i]) begin
          if ($urandom % 3 == 0) begin
            req_range[i] = mk_range(int'($urandom_range(0, 60)) - 10, int'($urandom_range(0, 60)) - 10);
            req_valid[i] = 1'b1;
          end
        end else if ($urandom % 20 == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  task automatic wait_ready(output logic [N-1:0] r);
    int n = 0;
    while (req_ready == '0 && n < 50) begin @(negedge clk); n++; end
    check("ready_seen", req_ready != '0, 1);
    r = req_ready;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    check("idle_reached", busy, 0);
    @(negedge clk);
  endtask

  task automatic run_query(input int idx, input int s, input int e,
                           output logic [N-1:0] rdy, output int recalcs, output int gap,
                           output logic [N-1:0] rv, output logic [W-1:0] rt,
                           output logic [2*W-1:0] rng, output logic to);
    req_range[idx] = mk_range(s, e);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    wait_ready(rdy);
    req_valid[idx] = 1'b0;
    gap = 0; recalcs = 0; rng = '0;
    while (rsp_valid == '0 && gap < 60) begin
      @(negedge clk);
      gap++;
      if (eng_recalc) begin recalcs++; rng = eng_range; end
    end
    rv = rsp_valid; rt = rsp_time; to = timeout;
  endtask

  logic [N-1:0]   q_rdy, q_rv;
  logic [W-1:0]   q_rt;
  logic [2*W-1:0] q_rng;
  logic           q_to;
  int             q_rc, q_gap;

  initial begin : stim
    int got[5];
    int exp_order[5];
    int n, c;
    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_valid = '0; req_range = '0; eng_done = 1'b0; eng_result = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_range", eng_range, 0);
    check("reset_rsp_valid", rsp_valid, 0);

    // Round robin with all trackers continuously pending
    eng_mode = E_DIRECT; dir_result = W'(33);
    for (int i = 0; i < N; i++) req_range[i] = mk_range(i * 10, i * 10 + 5);
    req_valid = '1;
    n = 0; c = 0;
    while (n < 5 && c < 200) begin
      @(negedge clk); c++;
      if (req_ready != '0) begin got[n] = $clog2(req_ready); n++; end
    end
    req_valid = '0;
    check("rr_grant_count", n, 5);
    for (int k = 0; k < n; k++) check($sformatf("rr_grant_%0d", k), got[k], exp_order[k]);
    wait_idle();

    // Single query
    dir_result = W'(14);
    run_query(2, 10, 20, q_rdy, q_rc, q_gap, q_rv, q_rt, q_rng, q_to);
    check("single_ready", q_rdy, 4'b0100);
    check("single_range", q_rng, {32'd10, 32'd20});
    check("single_recalcs", q_rc, 1);
    check("single_latency", q_gap, 3);
    check("single_rsp_valid", q_rv, 4'b0100);
    check("single_rsp_time", q_rt, 14);
    @(negedge clk);

    // Empty window
    run_query(1, 30, 5, q_rdy, q_rc, q_gap, q_rv, q_rt, q_rng, q_to);
    check("empty_recalcs", q_rc, 0);
    check("empty_latency", q_gap, 1);
    check("empty_rsp_valid", q_rv, 4'b0010);
    check("empty_rsp_time", q_rt, 32'hFFFF_FFFF);
    @(negedge clk);

    // Engine reports no hit
    dir_result = '1;
    run_query(3, -4, 9, q_rdy, q_rc, q_gap, q_rv, q_rt, q_rng, q_to);
    check("nohit_rsp_valid", q_rv, 4'b1000);
    check("nohit_rsp_time", q_rt, 32'hFFFF_FFFF);
    check("nohit_timeout", q_to, 0);
    @(negedge clk);

    // Reset while waiting on the engine
    eng_mode = E_SILENT;
    req_range[1] = mk_range(0, 7);
    req_valid = 4'b0010;
    wait_ready(q_rdy);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    eng_mode = E_MANUAL; eng_done = 1'b1; eng_result = W'(77);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_reset_rsp_valid", rsp_valid, 0);
      check("post_reset_busy", busy, 0);
    end
    eng_done = 1'b0; eng_mode = E_DIRECT; dir_result = W'(3);
    req_range[1] = mk_range(1, 2); req_range[3] = mk_range(1, 2);
    req_valid = 4'b1010;
    wait_ready(q_rdy);
    req_valid = '0;
    check("post_reset_ptr_grant", q_rdy, 4'b0010);
    wait_idle();

    // Silent engine
    eng_mode = E_SILENT;
    req_range[0] = mk_range(0, 50);
    req_valid = 4'b0001;
    wait_ready(q_rdy);
    req_valid = '0;
`ifdef QUERY_TIMEOUT_EN
    q_gap = 0;
    while (rsp_valid == '0 && q_gap < 40) begin @(negedge clk); q_gap++; end
    check("to_latency", q_gap, TO + 1);
    check("to_pulse", timeout, 1);
    check("to_rsp_time", rsp_time, 32'hFFFF_FFFF);
    check("to_rsp_valid", rsp_valid, 4'b0001);
    eng_mode = E_MANUAL; eng_done = 1'b1; eng_result = W'(9);
    repeat (3) begin @(negedge clk); check("late_done_ignored", rsp_valid, 0); end
    eng_done = 1'b0;
`else
    repeat (20) begin
      @(negedge clk);
      check("silent_busy", busy, 1);
      check("silent_timeout", timeout, 0);
    end
    eng_mode = E_MANUAL; eng_done = 1'b1; eng_result = W'(5);
    @(negedge clk);
    eng_done = 1'b0;
    check("release_rsp_valid", rsp_valid, 4'b0001);
    check("release_rsp_time", rsp_time, 5);
`endif
    wait_idle();

    // Randomized traffic
    eng_mode = E_RANDOM;
    req_random = 1'b1;
    repeat (3000) @(negedge clk);
    req_random = 1'b0;
    @(negedge clk);
    req_valid = '0;
    wait_idle();
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
